mem_access_ctrl: RTL and testbench

- MEM-stage data-memory access controller; produces `mem_stall_MEM`, which the hazard control unit ORs into the global pipeline stall.
- Turns a load/store held in MEM into one request/acknowledge transaction on the data-memory bus, with byte enables for byte, half and word accesses.
- Extends load data (sign or zero) and reports misaligned accesses and bus timeouts.

---
 rtl/mem_access_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: one req/ack bus transaction per load/store,
// byte-lane enables, store replication, load extension, misalignment and timeout reporting.
module mem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_MEM,
    input  logic        store_MEM,
    input  logic [1:0]  size_MEM,
    input  logic        unsigned_MEM,
    input  logic [31:0] addr_MEM,
    input  logic [31:0] wdata_MEM,
    output logic        mem_stall_MEM,
    output logic [31:0] rdata_MEM,
    output logic        align_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // state | meaning
    // IDLE  | waiting for a load/store in MEM; stalls combinationally while one is present
    // REQ   | bus request outstanding, counting cycles toward timeout
    // DONE  | one-cycle release of the stall; error pulses and load data valid
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic              aerr_q, aerr_d;
    logic              berr_q, berr_d;

    logic              mem_op;
    logic              misaligned;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [31:0]       rd_shift;
    logic [31:0]       rd_ext;

    assign mem_op     = load_MEM | store_MEM;
    assign misaligned = ((size_MEM == 2'd1) & addr_MEM[0]) |
                        (size_MEM[1] & (addr_MEM[1:0] != 2'b00));

    always_comb begin
        case (size_MEM)
            2'd0:    be_new = 4'b0001 << addr_MEM[1:0];
            2'd1:    be_new = 4'b0011 << addr_MEM[1:0];
            default: be_new = 4'b1111;
        endcase
    end

    always_comb begin
        case (size_MEM)
            2'd0:    wdata_new = {4{wdata_MEM[7:0]}};
            2'd1:    wdata_new = {2{wdata_MEM[15:0]}};
            default: wdata_new = wdata_MEM;
        endcase
    end

    // Lane select uses the latched address, since addr_MEM may not be held by the bench/pipeline.
    assign rd_shift = bus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    rd_ext = uns_q ? {24'd0, rd_shift[7:0]}
                                    : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    rd_ext = uns_q ? {16'd0, rd_shift[15:0]}
                                    : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        size_d        = size_q;
        uns_d         = uns_q;
        we_d          = we_q;
        be_d          = be_q;
        aerr_d        = 1'b0;
        berr_d        = 1'b0;
        mem_stall_MEM = 1'b0;

        case (state_q)
            S_IDLE: begin
                mem_stall_MEM = mem_op;
                if (mem_op) begin
                    if (misaligned) begin
                        aerr_d  = 1'b1;
                        rdata_d = 32'd0;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_MEM;
                        size_d  = size_MEM;
                        uns_d   = unsigned_MEM;
                        we_d    = store_MEM;
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        cnt_d   = '0;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem_stall_MEM = 1'b1;
                cnt_d         = cnt_q + 1'b1;
                if (bus_ack) begin
                    rdata_d = rd_ext;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = 32'd0;
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reset) begin
            mem_stall_MEM = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            be_q    <= be_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    assign bus_req   = (state_q == S_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign rdata_MEM = rdata_q;
    assign align_err = aerr_q;
    assign bus_err   = berr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expectations queued at issue, popped at DONE.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        load_MEM, store_MEM, unsigned_MEM;
    logic [1:0]  size_MEM;
    logic [31:0] addr_MEM, wdata_MEM;
    logic        mem_stall_MEM;
    logic [31:0] rdata_MEM;
    logic        align_err, bus_err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic        we;
        logic        aerr;
        logic        berr;
        logic        chk_rd;
        int          stall;
        int          reqs;
    } exp_t;

    exp_t exp_q[$];

    mem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_MEM     (load_MEM),
        .store_MEM    (store_MEM),
        .size_MEM     (size_MEM),
        .unsigned_MEM (unsigned_MEM),
        .addr_MEM     (addr_MEM),
        .wdata_MEM    (wdata_MEM),
        .mem_stall_MEM(mem_stall_MEM),
        .rdata_MEM    (rdata_MEM),
        .align_err    (align_err),
        .bus_err      (bus_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
        case (sz)
            2'd0:    return {w[7:0], w[7:0], w[7:0], w[7:0]};
            2'd1:    return {w[15:0], w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic u,
                                            input logic [1:0] a, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0:    return u ? {24'd0, b} : {{24{b[7]}}, b};
            2'd1:    return u ? {16'd0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // ack_dly: REQ cycle in which the responder acks (0 = never)
    task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_dly);
        exp_t e, got;
        int   stall_cnt, req_cnt;
        bit   done, mis;
        @(negedge clk);
        load_MEM = ld; store_MEM = st; size_MEM = sz; unsigned_MEM = u;
        addr_MEM = a; wdata_MEM = wd; bus_rdata = rd; bus_ack = 1'b0;

        mis      = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        e.addr   = {a[31:2], 2'b00};
        e.wdata  = m_wdata(sz, wd);
        e.rdata  = (ack_dly >= 1 && ack_dly <= TO) ? m_rdata(sz, u, a[1:0], rd) : 32'd0;
        e.be     = m_be(sz, a[1:0]);
        e.we     = st;
        e.aerr   = mis;
        e.berr   = !mis && !(ack_dly >= 1 && ack_dly <= TO);
        e.chk_rd = ld && !mis;
        e.reqs   = mis ? 0 : ((ack_dly >= 1 && ack_dly <= TO) ? ack_dly : TO);
        e.stall  = 1 + e.reqs;
        exp_q.push_back(e);

        stall_cnt = 0; req_cnt = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            if (mem_stall_MEM) begin
                stall_cnt++;
                if (align_err || bus_err) chk("early_err_pulse", {align_err, bus_err}, 2'b00);
                if (bus_req) begin
                    req_cnt++;
                    chk("bus_addr", bus_addr, e.addr);
                    chk("bus_be", {28'd0, bus_be}, {28'd0, e.be});
                    chk("bus_we", {31'd0, bus_we}, {31'd0, e.we});
                    if (st) chk("bus_wdata", bus_wdata, e.wdata);
                    bus_ack = (ack_dly != 0 && req_cnt == ack_dly);
                end else begin
                    bus_ack = 1'b0;
                end
                @(negedge clk);
            end else begin
                done    = 1;
                bus_ack = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    got = exp_q.pop_front();
                    chk("stall_cycles", stall_cnt, got.stall);
                    chk("req_cycles", req_cnt, got.reqs);
                    chk("bus_req_done", {31'd0, bus_req}, 32'd0);
                    chk("align_err", {31'd0, align_err}, {31'd0, got.aerr});
                    chk("bus_err", {31'd0, bus_err}, {31'd0, got.berr});
                    if (got.chk_rd) chk("rdata_MEM", rdata_MEM, got.rdata);
                end
            end
        end
        if (!done) chk("op_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        load_MEM = 1'b1; store_MEM = 1'b0; size_MEM = 2'd2; unsigned_MEM = 1'b0;
        addr_MEM = 32'h100; wdata_MEM = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'd0, mem_stall_MEM}, 32'd0);
        chk("rst_req", {31'd0, bus_req}, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", rdata_MEM, 32'd0);
        chk("rst_errs", {30'd0, align_err, bus_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0; load_MEM = 1'b0;
        #1 chk("nonmem_stall", {31'd0, mem_stall_MEM}, 32'd0);
        @(negedge clk);
        #1 chk("nonmem_stall2", {31'd0, mem_stall_MEM}, 32'd0);

        // lw, lb, lbu, lh
        run_op(1, 0, 2'd2, 0, 32'h100, 32'd0, 32'hDEADBEEF, 1);
        run_op(1, 0, 2'd0, 0, 32'h203, 32'd0, 32'h80FF1234, 1);
        run_op(1, 0, 2'd0, 1, 32'h203, 32'd0, 32'h80FF1234, 1);
        run_op(1, 0, 2'd2 - 2'd1, 0, 32'h202, 32'd0, 32'h80FF1234, 2);
        // sb with delayed ack
        run_op(0, 1, 2'd0, 0, 32'h1, 32'h000000AB, 32'd0, 4);
        // misaligned lw and lh
        run_op(1, 0, 2'd2, 0, 32'h102, 32'd0, 32'h12345678, 1);
        run_op(1, 0, 2'd1, 0, 32'h105, 32'd0, 32'h12345678, 1);
        run_op(0, 1, 2'd3, 0, 32'h201, 32'h11223344, 32'd0, 1);
        // timeout without ack, then ack in the last allowed cycle
        run_op(1, 0, 2'd2, 0, 32'h400, 32'd0, 32'hCAFEF00D, 0);
        run_op(1, 0, 2'd2, 0, 32'h400, 32'd0, 32'hCAFEF00D, TO);
        // back-to-back sw then lw
        run_op(0, 1, 2'd2, 0, 32'h300, 32'hA5A55A5A, 32'd0, 1);
        run_op(1, 0, 2'd2, 0, 32'h300, 32'd0, 32'h0BADF00D, 1);
        run_op(0, 1, 2'd1, 0, 32'h302, 32'h0000BEEF, 32'd0, 2);
        run_op(1, 0, 2'd1, 1, 32'h302, 32'd0, 32'hBEEF0000, 3);

        for (int i = 0; i < 10; i++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a  = $urandom & 32'hFFFF_FFFC;
            if (sz == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
            if (sz == 2'd1) a[1]   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                run_op(1, 0, sz, 1'($urandom_range(0, 1)), a, 32'd0, $urandom, $urandom_range(1, 3));
            else
                run_op(0, 1, sz, 0, a, $urandom, 32'd0, $urandom_range(1, 3));
        end

        // reset during REQ, stale ack afterwards
        @(negedge clk);
        load_MEM = 1'b1; store_MEM = 1'b0; size_MEM = 2'd2; addr_MEM = 32'h500;
        bus_ack = 1'b0; bus_rdata = 32'h77777777;
        @(negedge clk);
        #1 chk("rst_mid_req_up", {31'd0, bus_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_req", {31'd0, bus_req}, 32'd0);
        chk("rst_mid_stall", {31'd0, mem_stall_MEM}, 32'd0);
        @(negedge clk);
        reset = 1'b0; load_MEM = 1'b0; bus_ack = 1'b1;
        #1 chk("post_rst_stall", {31'd0, mem_stall_MEM}, 32'd0);
        @(posedge clk);
        #1;
        chk("stale_ack_req", {31'd0, bus_req}, 32'd0);
        chk("stale_ack_rdata", rdata_MEM, 32'd0);
        chk("stale_ack_err", {30'd0, align_err, bus_err}, 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        run_op(1, 0, 2'd2, 0, 32'h600, 32'd0, 32'h13572468, 1);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
